fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the LEGv8 pipeline: holds the 64-bit PC and drives the
//  instruction-memory request/ready handshake. It captures each fetched word into the
//  IF/ID register and exports pc_plus4 to the next-PC mux2 (input e1).
//  The mux2 output q returns as pc_next; redirect (PCSrc) flushes and reloads the PC.
// PARAMETERS
//  N        64  PC / address width
//  INSTR_W  32  instruction word width
//  RESET_PC 0   PC value loaded on reset
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  reset        in   1        synchronous, active-high reset
//  pc_next      in   N        next PC from mux2 q (pc_plus4 or branch target)
//  redirect     in   1        branch taken (PCSrc): flush and load pc_next
//  stall        in   1        hazard unit: hold IF/ID and PC
//  pc           out  N        current PC register
//  pc_plus4     out  N        pc + 4, combinational, modulo 2^N
//  imem_req     out  1        fetch request
//  imem_addr    out  N        fetch address (= pc)
//  imem_ready   in   1        memory accepts; imem_rdata valid this cycle
//  imem_rdata   in   INSTR_W  instruction word
//  if_id_valid  out  1        IF/ID holds a valid instruction
//  if_id_pc     out  N        PC of the IF/ID instruction
//  if_id_instr  out  INSTR_W  IF/ID instruction
// BEHAVIOUR
//  - Reset: pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, imem_req=0,
//    skid buffer cleared, state=BOOT. Reset overrides all other inputs.
//  - FSM states: BOOT, FETCH, HELD.
//    BOOT : imem_req=0; next cycle -> FETCH.
//    FETCH: imem_req=1, imem_addr=pc. Fetch completes on req&ready.
//      On completion with stall=0: IF/ID <= {1,pc,rdata}; pc <= pc_next; stay in FETCH.
//      On completion with stall=1: skid <= {pc,rdata}; pc held; -> HELD.
//    HELD : imem_req=0. When stall=0: IF/ID <= {1,skid}; pc <= pc_next; -> FETCH.
//  - IF/ID loads only when stall=0. If stall=0 and nothing completes, if_id_valid <= 0 (bubble).
//    While stall=1, all IF/ID fields are held unchanged.
//  - imem_addr is stable while imem_req=1 and ready=0; it changes only on redirect.
//  - redirect (priority over stall and completion): pc <= pc_next; if_id_valid <= 0.
//    Skid buffer and any same-cycle imem_rdata are discarded; state -> FETCH.
//  - Fetch-to-IF/ID latency: 1 cycle after req&ready (no stall). Throughput: 1 instr/cycle
//    when ready is held high.
//  - PC arithmetic is N-bit unsigned and wraps silently (2^N-4 + 4 = 0).
//    Alignment is not checked.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds out ports perf_fetched[31:0] and perf_stalls[31:0].
//    perf_fetched +1 per word written into IF/ID (not discarded words).
//    perf_stalls +1 per cycle with stall=1 and redirect=0.
//    Both wrap at 2^32 and clear on reset.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset=1 two cycles, RESET_PC=0 -> pc=0, imem_req=0, if_id_valid=0.
//    Cycle after release: imem_req=1, imem_addr=0.
//  2 Streaming: ready=1, pc_next=pc_plus4, rdata=0x8B020020, 0x8B030041, ...
//    -> if_id_pc=0,4,8,... on consecutive cycles, each with its word, valid=1.
//  3 ready=0 for 3 cycles at pc=8 -> imem_addr stays 8 and if_id_valid=0 each cycle.
//    ready=1 -> next cycle if_id_pc=8.
//  4 stall=1 on the completion cycle at pc=0xC -> state HELD, pc stays 0xC, IF/ID unchanged.
//    stall=0 -> next cycle if_id_pc=0xC, then fetch resumes at 0x10.
//  5 redirect=1 with stall=1 and pc_next=0x40 -> next cycle pc=0x40, if_id_valid=0,
//    imem_addr=0x40; the old skid word is never seen in IF/ID.
//  6 pc=0xFFFF_FFFF_FFFF_FFFC, pc_next=pc_plus4 -> pc_plus4=0 and pc wraps to 0.
//    With FETCH_PERF_EN, perf_fetched counts only delivered words.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - LEGv8 instruction-fetch stage with PC, imem handshake, skid buffer and IF/ID register (optional counters: FETCH_PERF_EN)
module fetch_stage #(
   parameter int            N        = 64,
   parameter int            INSTR_W  = 32,
   parameter logic [N-1:0]  RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N-1:0]        pc_next,
   input  logic                redirect,
   input  logic                stall,
   output logic [N-1:0]        pc,
   output logic [N-1:0]        pc_plus4,
   output logic                imem_req,
   output logic [N-1:0]        imem_addr,
   input  logic                imem_ready,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                if_id_valid,
   output logic [N-1:0]        if_id_pc,
`ifdef FETCH_PERF_EN
   output logic [INSTR_W-1:0]  if_id_instr,
   output logic [31:0]         perf_fetched,
   output logic [31:0]         perf_stalls
`else
   output logic [INSTR_W-1:0]  if_id_instr
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [N-1:0]        skid_pc;
   logic [INSTR_W-1:0]  skid_instr;

   logic                complete;
   logic                pc_load;
   logic                skid_load;
   logic                ifid_load;
   logic                ifid_from_skid;
   logic                ifid_bubble;

   assign pc_plus4  = pc + N'(4);
   assign imem_addr = pc;
   assign complete  = imem_req & imem_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and datapath control; redirect overrides everything below it
   always_comb begin
      state_next     = state;
      imem_req       = 1'b0;
      pc_load        = 1'b0;
      skid_load      = 1'b0;
      ifid_load      = 1'b0;
      ifid_from_skid = 1'b0;
      ifid_bubble    = 1'b0;

      case (state)
         BOOT: begin
            state_next  = FETCH;
            ifid_bubble = ~stall;
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if (!stall) begin
                  ifid_load = 1'b1;
                  pc_load   = 1'b1;
               end else begin
                  skid_load  = 1'b1;
                  state_next = HELD;
               end
            end else begin
               ifid_bubble = ~stall;
            end
         end
         HELD: begin
            if (!stall) begin
               ifid_load      = 1'b1;
               ifid_from_skid = 1'b1;
               pc_load        = 1'b1;
               state_next     = FETCH;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase

      if (redirect) begin
         pc_load     = 1'b1;
         skid_load   = 1'b0;
         ifid_load   = 1'b0;
         ifid_bubble = 1'b1;
         state_next  = FETCH;
      end
   end

   // PC, skid buffer and IF/ID register
   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         skid_pc     <= '0;
         skid_instr  <= '0;
         if_id_valid <= 1'b0;
         if_id_pc    <= '0;
         if_id_instr <= '0;
      end else begin
         if (pc_load) begin
            pc <= pc_next;
         end
         if (skid_load) begin
            skid_pc    <= pc;
            skid_instr <= imem_rdata;
         end
         if (ifid_load) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= ifid_from_skid ? skid_pc : pc;
            if_id_instr <= ifid_from_skid ? skid_instr : imem_rdata;
         end else if (ifid_bubble) begin
            if_id_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   // Delivered-word and stall-cycle counters, free-running with wrap
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stalls  <= '0;
      end else begin
         if (ifid_load) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (stall && !redirect) begin
            perf_stalls <= perf_stalls + 32'd1;
         end
      end
   end
`endif

   // A completion with the complete flag unused in some builds is still part of the handshake
   logic unused_complete;
   assign unused_complete = complete;

endmodule
